// File: rtl/fetch_stage_pkg.sv
// Shared widths, PC-select encodings and IF/ID record for the fetch stage.
package fetch_stage_pkg;

  localparam int ADDR_LEN        = 12;
  localparam int INSTRUCTION_LEN = 16;

  // PC source chosen by execute.
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_OFFSET = 2'b01;
  localparam logic [1:0] PC_SEL_CONST  = 2'b10;
  localparam logic [1:0] PC_SEL_STACK  = 2'b11;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [INSTRUCTION_LEN-1:0] instruction;
    logic [ADDR_LEN-1:0]        pc;
    logic                       valid;
  } ifid_t;

  // An all-zero record doubles as the bubble and the reset value.
  localparam ifid_t IFID_BUBBLE = '0;

  // Branch target is relative to the instruction after the branch; the
  // addition wraps naturally at the address width.
  function automatic logic [ADDR_LEN-1:0] branchTarget(
    input logic [ADDR_LEN-1:0] pc,
    input logic [7:0]          offset
  );
    logic [ADDR_LEN-1:0] sextOffset;
    sextOffset = {{(ADDR_LEN-8){offset[7]}}, offset};
    return pc + ADDR_LEN'(1) + sextOffset;
  endfunction

endpackage

// File: rtl/fetch_stage_return_stack.sv
// Return-address stack: LIFO of call return addresses with sticky
// overflow/underflow flags. Pushes into a full stack and pops from an empty
// stack leave the pointer alone.
module return_stack
  import fetch_stage_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [ADDR_LEN-1:0] push_data,
  output logic [ADDR_LEN-1:0] top,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]     r_sp;
  logic [ADDR_LEN-1:0] r_mem [STACK_DEPTH];
  logic                r_overflow;
  logic                r_underflow;

  logic                w_empty;
  logic                w_full;
  logic [IDX_W-1:0]    w_wrIdx;
  logic [IDX_W-1:0]    w_topIdx;

  assign w_empty  = (r_sp == '0);
  assign w_full   = (r_sp == SP_W'(STACK_DEPTH));
  // Writes only happen when not full, so the truncated pointer stays in range.
  assign w_wrIdx  = IDX_W'(r_sp);
  // Only meaningful when not empty; the empty case is masked below.
  assign w_topIdx = IDX_W'(r_sp - SP_W'(1));

  assign top       = w_empty ? '0 : r_mem[w_topIdx];
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Stack pointer and sticky error flags; flags clear only on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_sp <= r_sp + SP_W'(1);
        end
      end else if (pop) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_sp <= r_sp - SP_W'(1);
        end
      end
    end
  end

  // Entry storage; no reset needed since the pointer guards stale entries.
  always_ff @(posedge clk) begin
    if (rst && push && !w_full) begin
      r_mem[w_wrIdx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect target mux, return-address
// stack and the IF/ID pipeline register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [1:0]                 EX_pc_sel,
  input  logic [ADDR_LEN-1:0]        EX_pc,
  input  logic [7:0]                 EX_offset,
  input  logic [ADDR_LEN-1:0]        EX_const,
  input  logic                       EX_push,
  output logic [ADDR_LEN-1:0]        imem_addr,
  input  logic [INSTRUCTION_LEN-1:0] imem_data,
  output logic [INSTRUCTION_LEN-1:0] PR1_instruction,
  output logic [ADDR_LEN-1:0]        PR1_pc,
  output logic                       PR1_valid,
  output logic                       flush_ID,
  output logic                       stack_overflow,
  output logic                       stack_underflow
);

  logic [ADDR_LEN-1:0] r_pc;
  ifid_t               r_ifid;

  logic                w_redirect;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_LEN-1:0] w_target;
  logic [ADDR_LEN-1:0] w_stackTop;
  logic                w_stackEmpty;
  logic                w_unusedStackFull;

  // Any non-sequential select is a redirect; a push only counts alongside
  // an absolute jump, which is how calls are encoded.
  assign w_redirect = (EX_pc_sel != PC_SEL_SEQ);
  assign w_push     = EX_push && (EX_pc_sel == PC_SEL_CONST);
  assign w_pop      = (EX_pc_sel == PC_SEL_STACK);

  return_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (EX_pc + ADDR_LEN'(1)),
    .top       (w_stackTop),
    .empty     (w_stackEmpty),
    .full      (w_unusedStackFull),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

  // Redirect target selection; a return from an empty stack goes to 0.
  always_comb begin
    w_target = '0;
    unique case (EX_pc_sel)
      PC_SEL_OFFSET: w_target = branchTarget(EX_pc, EX_offset);
      PC_SEL_CONST:  w_target = EX_const;
      PC_SEL_STACK:  w_target = w_stackEmpty ? '0 : w_stackTop;
      default:       w_target = '0;
    endcase
  end

  // PC register: a redirect beats stall, otherwise advance unless stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (!stall) begin
      r_pc <= r_pc + ADDR_LEN'(1);
    end
  end

  // IF/ID register: bubble on redirect, capture the fetch otherwise, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ifid <= IFID_BUBBLE;
    end else if (w_redirect) begin
      r_ifid <= IFID_BUBBLE;
    end else if (!stall) begin
      r_ifid.instruction <= imem_data;
      r_ifid.pc          <= r_pc;
      r_ifid.valid       <= 1'b1;
    end
  end

  assign imem_addr       = r_pc;
  assign PR1_instruction = r_ifid.instruction;
  assign PR1_pc          = r_ifid.pc;
  assign PR1_valid       = r_ifid.valid;
  assign flush_ID        = w_redirect;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; instruction memory returns its own
// address as data so fetched instructions are easy to predict.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                       clk;
  logic                       rst;
  logic                       stall;
  logic [1:0]                 exPcSel;
  logic [ADDR_LEN-1:0]        exPc;
  logic [7:0]                 exOffset;
  logic [ADDR_LEN-1:0]        exConst;
  logic                       exPush;
  logic [ADDR_LEN-1:0]        imemAddr;
  logic [INSTRUCTION_LEN-1:0] imemData;
  logic [INSTRUCTION_LEN-1:0] pr1Instruction;
  logic [ADDR_LEN-1:0]        pr1Pc;
  logic                       pr1Valid;
  logic                       flushId;
  logic                       stackOverflow;
  logic                       stackUnderflow;

  int checkCount = 0;
  int errorCount = 0;

  fetch_stage #(
    .STACK_DEPTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .EX_pc_sel       (exPcSel),
    .EX_pc           (exPc),
    .EX_offset       (exOffset),
    .EX_const        (exConst),
    .EX_push         (exPush),
    .imem_addr       (imemAddr),
    .imem_data       (imemData),
    .PR1_instruction (pr1Instruction),
    .PR1_pc          (pr1Pc),
    .PR1_valid       (pr1Valid),
    .flush_ID        (flushId),
    .stack_overflow  (stackOverflow),
    .stack_underflow (stackUnderflow)
  );

  // Memory image mem[i] = i, read combinationally.
  assign imemData = INSTRUCTION_LEN'(imemAddr);

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [ADDR_LEN-1:0] pc,
                               input logic [7:0] offset, input logic [ADDR_LEN-1:0] cnst,
                               input logic push, input logic hold);
    exPcSel  = sel;
    exPc     = pc;
    exOffset = offset;
    exConst  = cnst;
    exPush   = push;
    stall    = hold;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; expected values are hand-computed from the memory image.
  initial begin
    rst = 1'b0;
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);

    // Reset and release
    tick();
    tick();
    checkOutput("reset_valid", 32'(pr1Valid), 32'd0);
    checkOutput("reset_pc", 32'(imemAddr), 32'h000);
    checkOutput("reset_ovf", 32'(stackOverflow), 32'd0);
    checkOutput("reset_unf", 32'(stackUnderflow), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("first_valid", 32'(pr1Valid), 32'd1);
    checkOutput("first_pc", 32'(pr1Pc), 32'h000);
    checkOutput("first_imem", 32'(imemAddr), 32'h001);
    tick();
    tick();
    checkOutput("rel_pr1pc", 32'(pr1Pc), 32'h002);
    checkOutput("rel_instr", 32'(pr1Instruction), 32'h002);
    checkOutput("rel_imem", 32'(imemAddr), 32'h003);

    // Branch backwards by 3 from 0x010
    applyStimulus(PC_SEL_OFFSET, 12'h010, 8'hFD, '0, 1'b0, 1'b0);
    #1;
    checkOutput("br_flush", 32'(flushId), 32'd1);
    tick();
    checkOutput("br_imem", 32'(imemAddr), 32'h00E);
    checkOutput("br_bubble_v", 32'(pr1Valid), 32'd0);
    checkOutput("br_bubble_pc", 32'(pr1Pc), 32'h000);
    checkOutput("br_bubble_in", 32'(pr1Instruction), 32'h000);
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("seq_noflush", 32'(flushId), 32'd0);
    tick();
    checkOutput("br_tgt_valid", 32'(pr1Valid), 32'd1);
    checkOutput("br_tgt_pc", 32'(pr1Pc), 32'h00E);
    checkOutput("br_tgt_in", 32'(pr1Instruction), 32'h00E);
    checkOutput("br_tgt_imem", 32'(imemAddr), 32'h00F);

    // Branch +1 from 0xFFE wraps to 0x000
    applyStimulus(PC_SEL_OFFSET, 12'hFFE, 8'h01, '0, 1'b0, 1'b0);
    tick();
    checkOutput("br_wrap", 32'(imemAddr), 32'h000);
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("pre_stall_pc", 32'(pr1Pc), 32'h000);

    // Stall holds PC and IF/ID for 3 cycles
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("stall_imem", 32'(imemAddr), 32'h001);
    checkOutput("stall_pr1pc", 32'(pr1Pc), 32'h000);
    checkOutput("stall_valid", 32'(pr1Valid), 32'd1);
    // Redirect beats stall
    applyStimulus(PC_SEL_CONST, '0, '0, 12'h123, 1'b0, 1'b1);
    tick();
    checkOutput("stallred_imem", 32'(imemAddr), 32'h123);
    checkOutput("stallred_valid", 32'(pr1Valid), 32'd0);

    // Sequential PC wrap 0xFFF -> 0x000
    applyStimulus(PC_SEL_CONST, '0, '0, 12'hFFF, 1'b0, 1'b0);
    tick();
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("wrap_imem", 32'(imemAddr), 32'h000);
    checkOutput("wrap_pr1pc", 32'(pr1Pc), 32'hFFF);
    checkOutput("wrap_instr", 32'(pr1Instruction), 32'hFFF);

    // Single call and return
    applyStimulus(PC_SEL_CONST, 12'h040, '0, 12'h200, 1'b1, 1'b0);
    tick();
    checkOutput("call_imem", 32'(imemAddr), 32'h200);
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("call_tgt_pc", 32'(pr1Pc), 32'h200);
    applyStimulus(PC_SEL_STACK, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("ret_imem", 32'(imemAddr), 32'h041);

    // Nested calls, second call immediately after the first
    applyStimulus(PC_SEL_CONST, 12'h040, '0, 12'h200, 1'b1, 1'b0);
    tick();
    applyStimulus(PC_SEL_CONST, 12'h300, '0, 12'h400, 1'b1, 1'b0);
    tick();
    checkOutput("ncall_imem", 32'(imemAddr), 32'h400);
    applyStimulus(PC_SEL_STACK, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("nret1_imem", 32'(imemAddr), 32'h301);
    tick();
    checkOutput("nret2_imem", 32'(imemAddr), 32'h041);
    checkOutput("nret_unf", 32'(stackUnderflow), 32'd0);

    // Fill the stack, then one more push is dropped
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(PC_SEL_CONST, ADDR_LEN'(i * 16), '0, 12'h600, 1'b1, 1'b0);
      tick();
      if (i == 8) checkOutput("fill_ovf", 32'(stackOverflow), 32'd0);
    end
    checkOutput("over_ovf", 32'(stackOverflow), 32'd1);
    // Pops return entries 8..1
    for (int k = 8; k >= 1; k--) begin
      applyStimulus(PC_SEL_STACK, '0, '0, '0, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("pop%0d", k), 32'(imemAddr), 32'(k * 16 + 1));
    end
    checkOutput("pops_unf", 32'(stackUnderflow), 32'd0);
    // Push flagged with a branch select must be ignored
    applyStimulus(PC_SEL_OFFSET, 12'h500, 8'h00, '0, 1'b1, 1'b0);
    tick();
    checkOutput("ignpush_imem", 32'(imemAddr), 32'h501);
    // Pop from empty stack
    applyStimulus(PC_SEL_STACK, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("unf_imem", 32'(imemAddr), 32'h000);
    checkOutput("unf_flag", 32'(stackUnderflow), 32'd1);

    // Flags are sticky
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("sticky_ovf", 32'(stackOverflow), 32'd1);
    checkOutput("sticky_unf", 32'(stackUnderflow), 32'd1);

    // Reset during a stalled redirect wins
    applyStimulus(PC_SEL_CONST, '0, '0, 12'h777, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    checkOutput("midrst_imem", 32'(imemAddr), 32'h000);
    checkOutput("midrst_valid", 32'(pr1Valid), 32'd0);
    checkOutput("midrst_pr1pc", 32'(pr1Pc), 32'h000);
    checkOutput("midrst_ovf", 32'(stackOverflow), 32'd0);
    checkOutput("midrst_unf", 32'(stackUnderflow), 32'd0);
    rst = 1'b1;
    applyStimulus(PC_SEL_SEQ, '0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("post_valid", 32'(pr1Valid), 32'd1);
    checkOutput("post_imem", 32'(imemAddr), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core: owns the PC, the return-address stack and the IF/ID pipeline register, and drives the instruction memory address. It sits directly upstream of the ID/EX register. Decode reads the `PR1_*` outputs; execute sends resolved branch, jump, call and return requests back to it.

## Interface
- `STACK_DEPTH`, 8: return-address stack entries, minimum 2.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low.
- `stall` in 1: hazard-unit hold; freezes PC and IF/ID.
- `EX_pc_sel` in 2: 00 sequential, 01 branch offset, 10 jump const, 11 return (stack).
- `EX_pc` in `ADDR_LEN`: PC of the instruction in EX.
- `EX_offset` in 8: signed branch displacement.
- `EX_const` in `ADDR_LEN`: absolute jump target.
- `EX_push` in 1: call; push `EX_pc+1`. Legal only with `EX_pc_sel`=10.
- `imem_addr` out `ADDR_LEN`: instruction memory address, equal to PC.
- `imem_data` in `INSTRUCTION_LEN`: combinational read data for `imem_addr`.
- `PR1_instruction` out `INSTRUCTION_LEN`: IF/ID instruction.
- `PR1_pc` out `ADDR_LEN`: PC of `PR1_instruction`.
- `PR1_valid` out 1: 0 means bubble.
- `flush_ID` out 1: combinational, high when `EX_pc_sel`≠00; ID/EX loads a bubble.
- `stack_overflow` out 1: sticky error flag.
- `stack_underflow` out 1: sticky error flag.

## Operation
- **Redirect**: a redirect is active when `EX_pc_sel`≠00. On an active redirect:
  - PC loads the target.
  - IF/ID loads a bubble: `PR1_valid`=0, `PR1_instruction`=0, `PR1_pc`=0.
  - Redirect beats `stall`.
- **Targets**:
  - 01: `EX_pc + 1 + sext(EX_offset)`, mod 2^`ADDR_LEN`.
  - 10: `EX_const`.
  - 11: top of stack.
- **Sequential**: with no redirect and no stall, PC loads PC+1, wrapping 0xFFF to 0x000. IF/ID loads {`imem_data`, PC, valid=1}.
- **Stall**: with `stall` and no redirect, PC and all IF/ID outputs hold.
- **Return-address stack**: LIFO with pointer `sp` in 0..`STACK_DEPTH`.
  - Push writes `EX_pc+1` at `sp` and increments `sp`.
  - Pop (`EX_pc_sel`=11) reads entry `sp-1` and decrements `sp`.
  - Push when full is dropped: contents and `sp` unchanged, `stack_overflow` set.
  - Pop when empty gives target 0 and leaves `sp`=0; `stack_underflow` set.
  - Stack operations are never gated by `stall`.
  - `EX_push` with `EX_pc_sel`≠10 is ignored.
- **Reset** (rst=0 at a rising edge): PC=0, `sp`=0, `PR1_*`=0, `PR1_valid`=0, both flags=0. Stack RAM contents are don't-care. Reset overrides every other input.

## Timing
- All state updates on the rising edge of `clk`. `imem_addr` is registered, since it is the PC.
- Fetch latency: an instruction at address A appears on `PR1_*` one edge after PC=A.
- First edge with rst=1: IF/ID captures address 0 with valid=1, and PC becomes 1.
- Redirect resolved in EX in cycle n:
  - Edge n+1: PC=target, IF/ID bubble.
  - Edge n+2: the target instruction is valid in IF/ID.
  - Penalty is 2 bubbles: IF/ID here, plus ID/EX via `flush_ID`.
- Call then immediate return: the pop in a later cycle sees the pushed entry, since the push commits at edge n+1.
- Reset asserted mid-stall or mid-redirect: state goes to reset values at that edge; the pending redirect is lost.

## Structure
- `defines.sv` provides `ADDR_LEN` (12), `INSTRUCTION_LEN`, and localparams `PC_SEL_SEQ`/`PC_SEL_OFFSET`/`PC_SEL_CONST`/`PC_SEL_STACK`.
- Sub-module `return_stack`:
  - Parameter: `STACK_DEPTH`.
  - Ports: clk, rst, push, pop, push_data, top, empty, full, overflow, underflow.
- The top level holds the PC register, target mux, IF/ID register and `flush_ID`.

## Test plan
- **Reset release**: rst low 2 cycles, then high, with imem holding `mem[i]=i`. Expect `PR1_valid`=0 during reset; after 3 edges `PR1_pc`=2, `PR1_instruction`=2, `imem_addr`=3.
- **Branch**: `EX_pc_sel`=01, `EX_pc`=0x010, `EX_offset`=-3 (0xFD) for 1 cycle. Next edge: `imem_addr`=0x00E, `PR1_valid`=0, `flush_ID`=1 during the request cycle. A following offset of +1 from 0xFFE gives 0x000.
- **Stall vs redirect**: `stall`=1 for 3 cycles. PC and `PR1_*` hold. Then `stall`=1 with `EX_pc_sel`=10, `EX_const`=0x123: PC=0x123, bubble inserted.
- **Call/return**: push with `EX_pc`=0x040, jump to 0x200; later `EX_pc_sel`=11. Expect `imem_addr`=0x041. Nested calls 0x040 and 0x300 return 0x301, then 0x041.
- **Overflow/underflow** with `STACK_DEPTH`=8:
  - 9 pushes: `stack_overflow`=1, and 8 pops return entries 8..1.
  - A 9th pop: target 0, `stack_underflow`=1.
  - Both flags clear only on rst=0.
